pll_lock_ctrl: RTL and testbench

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_lock_ctrl.sv | 154 +++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up controller: pulses the PLL reset, waits for a synchronized lock,
// requires the lock to stay stable before declaring ready, retries on timeout
// and parks in FAIL once the retry budget is spent.
module pll_lock_ctrl #(
    parameter int unsigned RST_CYCLES         = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT       = 65536,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic       clkin1,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    // One shared counter, wide enough for the largest terminal count.
    localparam int unsigned MAX_A     = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_PARAM = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CNT_W     = (MAX_PARAM > 1) ? $clog2(MAX_PARAM) : 1;

    localparam logic [CNT_W-1:0] C_RST_END    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_END = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TMO_END    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
    localparam logic [3:0]       C_MAX_RETRY  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_READY     = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_lock_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry;
    logic             r_pll_rst;
    logic             r_ready;
    logic             r_lock_lost;
    logic             r_fail;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_retry_nxt;
    logic             w_lock_lost_nxt;

    // Two-flop synchronizer bringing the asynchronous lock into clkin1.
    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_lock;
            r_lock_s <= r_sync1;
        end
    end

    // Next-state, counter and retry decisions; relock_req outranks lock events.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + C_ONE;
        w_retry_nxt     = r_retry;
        w_lock_lost_nxt = 1'b0;

        if (relock_req && (r_state != S_RESET_PLL)) begin
            w_state_nxt = S_RESET_PLL;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == C_RST_END) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_nxt = S_STABILIZE;
                    end else if (r_cnt == C_TMO_END) begin
                        if (r_retry < C_MAX_RETRY) begin
                            w_retry_nxt = r_retry + 4'd1;
                            w_state_nxt = S_RESET_PLL;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end
                end
                S_STABILIZE: begin
                    if (!r_lock_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end else if (r_cnt == C_STABLE_END) begin
                        w_state_nxt = S_READY;
                        w_retry_nxt = '0;
                    end
                end
                S_READY: begin
                    w_cnt_nxt = r_cnt;
                    if (!r_lock_s) begin
                        w_state_nxt     = S_RESET_PLL;
                        w_lock_lost_nxt = 1'b1;
                    end
                end
                S_FAIL: begin
                    w_cnt_nxt = r_cnt;
                end
                default: begin
                    w_state_nxt = S_RESET_PLL;
                end
            endcase
        end

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    // State register plus outputs registered from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_rst   <= (w_state_nxt == S_RESET_PLL);
            r_ready     <= (w_state_nxt == S_READY);
            r_lock_lost <= w_lock_lost_nxt;
            r_fail      <= (w_state_nxt == S_FAIL);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;
    assign state     = r_state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: hand-derived vector table, a few directed corner
// sequences and randomized lock/relock/reset traffic against a timestamp model.
module tb_pll_lock_ctrl;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_STAB = 8;
    localparam int unsigned P_TMO  = 32;
    localparam int unsigned P_MAXR = 2;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_rst;
    logic       ready;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_ctrl #(
        .RST_CYCLES        (P_RST),
        .LOCK_STABLE_CYCLES(P_STAB),
        .LOCK_TIMEOUT      (P_TMO),
        .MAX_RETRIES       (P_MAXR)
    ) dut (
        .clkin1    (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase number, timestamp of phase entry, lock history.
    int m_phase;
    int m_cyc;
    int m_enter;
    int m_retry;
    bit m_lost;
    bit m_seen1;
    bit m_seen2;

    task automatic m_reset();
        m_phase = 0;
        m_enter = m_cyc;
        m_retry = 0;
        m_lost  = 1'b0;
        m_seen1 = 1'b0;
        m_seen2 = 1'b0;
    endtask

    task automatic m_step(input bit lk, input bit rq);
        int elapsed;
        int nph;
        elapsed = m_cyc - m_enter;
        nph     = m_phase;
        m_lost  = 1'b0;
        if (rq && m_phase != 0) begin
            nph     = 0;
            m_retry = 0;
        end else if (m_phase == 0) begin
            if (elapsed == P_RST - 1) nph = 1;
        end else if (m_phase == 1) begin
            if (m_seen2) nph = 2;
            else if (elapsed == P_TMO - 1) begin
                if (m_retry < P_MAXR) begin
                    m_retry++;
                    nph = 0;
                end else begin
                    nph = 4;
                end
            end
        end else if (m_phase == 2) begin
            if (!m_seen2) nph = 1;
            else if (elapsed == P_STAB - 1) begin
                nph     = 3;
                m_retry = 0;
            end
        end else if (m_phase == 3) begin
            if (!m_seen2) begin
                nph    = 0;
                m_lost = 1'b1;
            end
        end
        m_seen2 = m_seen1;
        m_seen1 = lk;
        m_cyc++;
        if (nph != m_phase) begin
            m_phase = nph;
            m_enter = m_cyc;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model.state",     32'(state),     32'(m_phase));
        chk("model.pll_rst",   32'(pll_rst),   32'(m_phase == 0));
        chk("model.ready",     32'(ready),     32'(m_phase == 3));
        chk("model.fail",      32'(fail),      32'(m_phase == 4));
        chk("model.retry_cnt", 32'(retry_cnt), 32'(m_retry));
        chk("model.lock_lost", 32'(lock_lost), 32'(m_lost));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else     m_step(pll_lock, relock_req);
        @(negedge clk);
        cmp_model();
    endtask

    typedef struct {
        bit lk;
        bit rq;
        int ticks;
        int st;
        bit prst;
        bit rdy;
        bit ll;
        bit fl;
        int rc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit lk, bit rq, int ticks, int st, bit prst, bit rdy, bit ll, bit fl, int rc);
        vec_t v;
        v.lk = lk; v.rq = rq; v.ticks = ticks; v.st = st;
        v.prst = prst; v.rdy = rdy; v.ll = ll; v.fl = fl; v.rc = rc;
        tbl.push_back(v);
    endfunction

    initial begin
        int mode;
        // bring-up: 4 reset edges, lock at e0, ready after e0+10
        add(0,0,  3, 0,1,0,0,0,0);
        add(0,0,  1, 1,0,0,0,0,0);
        add(1,0, 10, 2,0,0,0,0,0);
        add(1,0,  1, 3,0,1,0,0,0);
        // lock loss in READY
        add(0,0,  2, 3,0,1,0,0,0);
        add(0,0,  1, 0,1,0,1,0,0);
        add(0,0,  1, 0,1,0,0,0,0);
        add(0,0,  2, 0,1,0,0,0,0);
        add(0,0,  1, 1,0,0,0,0,0);
        // timeouts, retries, then FAIL
        add(0,0, 31, 1,0,0,0,0,0);
        add(0,0,  1, 0,1,0,0,0,1);
        add(0,0,  3, 0,1,0,0,0,1);
        add(0,0,  1, 1,0,0,0,0,1);
        add(0,0, 31, 1,0,0,0,0,1);
        add(0,0,  1, 0,1,0,0,0,2);
        add(0,0,  3, 0,1,0,0,0,2);
        add(0,0,  1, 1,0,0,0,0,2);
        add(0,0, 31, 1,0,0,0,0,2);
        add(0,0,  1, 4,0,0,0,1,2);
        add(0,0,120, 4,0,0,0,1,2);
        // recovery from FAIL
        add(1,1,  1, 0,1,0,0,0,0);
        add(1,0,  3, 0,1,0,0,0,0);
        add(1,0,  1, 1,0,0,0,0,0);
        add(1,0,  1, 2,0,0,0,0,0);
        add(1,0,  7, 2,0,0,0,0,0);
        add(1,0,  1, 3,0,1,0,0,0);
        // relock from READY, then glitch in STABILIZE at count 5
        add(1,1,  1, 0,1,0,0,0,0);
        add(1,0,  3, 0,1,0,0,0,0);
        add(1,0,  1, 1,0,0,0,0,0);
        add(1,0,  1, 2,0,0,0,0,0);
        add(1,0,  5, 2,0,0,0,0,0);
        add(0,0,  3, 1,0,0,0,0,0);
        add(1,0, 10, 2,0,0,0,0,0);
        add(1,0,  1, 3,0,1,0,0,0);
        // lock loss coinciding with relock: no lock_lost pulse
        add(0,0,  2, 3,0,1,0,0,0);
        add(0,1,  1, 0,1,0,0,0,0);
        add(0,0,  1, 0,1,0,0,0,0);
        add(0,0,  2, 0,1,0,0,0,0);
        add(0,0,  1, 1,0,0,0,0,0);

        rst = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
        m_cyc = 0;
        m_reset();
        tick();
        tick();
        chk("reset.state",     32'(state),     32'(0));
        chk("reset.pll_rst",   32'(pll_rst),   32'(1));
        chk("reset.ready",     32'(ready),     32'(0));
        chk("reset.lock_lost", 32'(lock_lost), 32'(0));
        chk("reset.fail",      32'(fail),      32'(0));
        chk("reset.retry_cnt", 32'(retry_cnt), 32'(0));
        rst = 1'b0;

        foreach (tbl[i]) begin
            pll_lock   = tbl[i].lk;
            relock_req = tbl[i].rq;
            for (int t = 0; t < tbl[i].ticks; t++) begin
                tick();
                relock_req = 1'b0;
            end
            chk($sformatf("vec%0d.state", i),     32'(state),     32'(tbl[i].st));
            chk($sformatf("vec%0d.pll_rst", i),   32'(pll_rst),   32'(tbl[i].prst));
            chk($sformatf("vec%0d.ready", i),     32'(ready),     32'(tbl[i].rdy));
            chk($sformatf("vec%0d.lock_lost", i), 32'(lock_lost), 32'(tbl[i].ll));
            chk($sformatf("vec%0d.fail", i),      32'(fail),      32'(tbl[i].fl));
            chk($sformatf("vec%0d.retry_cnt", i), 32'(retry_cnt), 32'(tbl[i].rc));
        end

        // asynchronous reset while READY
        pll_lock = 1'b1;
        for (int k = 0; k < 60 && state !== 3'd3; k++) tick();
        chk("async.reached_ready", 32'(ready), 32'(1));
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("async.pll_rst",   32'(pll_rst),   32'(1));
        chk("async.ready",     32'(ready),     32'(0));
        chk("async.lock_lost", 32'(lock_lost), 32'(0));
        chk("async.state",     32'(state),     32'(0));
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("postrst.pll_rst_held", 32'(pll_rst), 32'(1));
        tick();
        chk("postrst.pll_rst_drop", 32'(pll_rst), 32'(0));
        chk("postrst.state",        32'(state),   32'(1));

        // randomized traffic in 200-cycle segments of differing lock behaviour
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
                0: if ($urandom_range(0, 19) == 0) pll_lock = ~pll_lock;
                1: pll_lock = 1'b0;
                default: if ($urandom_range(0, 59) == 0) pll_lock = ~pll_lock;
            endcase
            relock_req = ($urandom_range(0, 149) == 0);
            if (rst) begin
                if ($urandom_range(0, 1) == 0) rst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #1;
                m_reset();
                cmp_model();
                @(negedge clk);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
